// File: rtl/absorb_feeder.sv
// -----------------------------------------------------------------------------
// absorb_feeder
//   Upstream sequencer for the absorb datapath. Accepts 256-bit AXI-Stream
//   message beats and hands one beat (or a parked carry) per cycle to absorb.
//   Owns the bytes-absorbed register, parks carry-over bytes across a
//   permutation, requests a permutation when the rate block fills, and flags
//   end of message with the final byte count left for the padding stage.
//
// Ports
//   clk_i, rst_ni       clock, async active-low reset
//   rate_i              rate in bits (1344/1088/832/576), stable per message
//   start_i             begin a new message (IDLE only)
//   s_t*_i, s_tready_o  AXI-Stream message input
//   msg_o, keep_o       beat (or carry) presented to absorb
//   absorb_we_o         absorb state commit strobe
//   bytes_absorbed_o    registered block fill count, to absorb
//   next_bytes_i        updated fill count from absorb
//   has_carry_i         absorb overflowed the block with this beat
//   carry_i/keep_i      overflow bytes and their valids from absorb
//   perm_start_o        one-cycle permutation request
//   perm_done_i         permutation complete pulse
//   absorb_done_o       one-cycle pulse, message fully absorbed
// -----------------------------------------------------------------------------
module absorb_feeder (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic [10:0]    rate_i,
    input  logic           start_i,
    input  logic [255:0]   s_tdata_i,
    input  logic [31:0]    s_tkeep_i,
    input  logic           s_tlast_i,
    input  logic           s_tvalid_i,
    output logic           s_tready_o,
    output logic [255:0]   msg_o,
    output logic [31:0]    keep_o,
    output logic           absorb_we_o,
    output logic [7:0]     bytes_absorbed_o,
    input  logic [7:0]     next_bytes_i,
    input  logic           has_carry_i,
    input  logic [191:0]   carry_i,
    input  logic [23:0]    carry_keep_i,
    output logic           perm_start_o,
    input  logic           perm_done_i,
    output logic           absorb_done_o
);

    localparam int unsigned DWIDTH            = 256;
    localparam int unsigned KEEP_WIDTH        = 32;
    localparam int unsigned CARRY_WIDTH       = 192;
    localparam int unsigned CARRY_KEEP_WIDTH  = 24;
    localparam int unsigned BYTE_ABSORB_WIDTH = 8;
    localparam int unsigned MSG_PAD_WIDTH     = DWIDTH - CARRY_WIDTH;
    localparam int unsigned KEEP_PAD_WIDTH    = KEEP_WIDTH - CARRY_KEEP_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FEED  = 3'd1,
        ST_PERM  = 3'd2,
        ST_CARRY = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    state_e                         state_q, state_d;
    logic [BYTE_ABSORB_WIDTH-1:0]   bytes_q, bytes_d;
    logic [CARRY_WIDTH-1:0]         carry_q, carry_d;
    logic [CARRY_KEEP_WIDTH-1:0]    carry_keep_q, carry_keep_d;
    logic                           carry_vld_q, carry_vld_d;
    logic                           last_pend_q, last_pend_d;
    logic                           perm_issued_q;
    logic                           block_full_c;

    // Block is full when absorb reports exactly rate/8 bytes.
    assign block_full_c = (next_bytes_i == BYTE_ABSORB_WIDTH'(rate_i >> 3));

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: fill count, parked carry, pending-last flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bytes_q       <= '0;
            carry_q       <= '0;
            carry_keep_q  <= '0;
            carry_vld_q   <= 1'b0;
            last_pend_q   <= 1'b0;
            perm_issued_q <= 1'b0;
        end else begin
            bytes_q       <= bytes_d;
            carry_q       <= carry_d;
            carry_keep_q  <= carry_keep_d;
            carry_vld_q   <= carry_vld_d;
            last_pend_q   <= last_pend_d;
            // High from the second PERM cycle on, so the request is a single pulse.
            perm_issued_q <= (state_q == ST_PERM);
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d      = state_q;
        bytes_d      = bytes_q;
        carry_d      = carry_q;
        carry_keep_d = carry_keep_q;
        carry_vld_d  = carry_vld_q;
        last_pend_d  = last_pend_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    bytes_d     = '0;
                    last_pend_d = 1'b0;
                    state_d     = ST_FEED;
                end
            end

            ST_FEED: begin
                // s_tready_o is 1 here, so valid alone is the handshake.
                if (s_tvalid_i) begin
                    bytes_d     = next_bytes_i;
                    last_pend_d = s_tlast_i;
                    if (has_carry_i) begin
                        carry_d      = carry_i;
                        carry_keep_d = carry_keep_i;
                        carry_vld_d  = 1'b1;
                        state_d      = ST_PERM;
                    end else if (block_full_c) begin
                        state_d = ST_PERM;
                    end else if (s_tlast_i) begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_PERM: begin
                if (perm_done_i) begin
                    bytes_d = '0;
                    if (carry_vld_q) begin
                        state_d = ST_CARRY;
                    end else if (last_pend_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_FEED;
                    end
                end
            end

            ST_CARRY: begin
                // At most 24 carry bytes into a fresh block: can never refill it.
                bytes_d     = next_bytes_i;
                carry_vld_d = 1'b0;
                state_d     = last_pend_q ? ST_DONE : ST_FEED;
            end

            ST_DONE: begin
                // Fill count is held for the padding stage until the next start.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode.
    always_comb begin
        s_tready_o    = 1'b0;
        msg_o         = '0;
        keep_o        = '0;
        absorb_we_o   = 1'b0;
        perm_start_o  = 1'b0;
        absorb_done_o = 1'b0;

        unique case (state_q)
            ST_FEED: begin
                s_tready_o  = 1'b1;
                msg_o       = s_tdata_i;
                keep_o      = s_tkeep_i;
                absorb_we_o = s_tvalid_i;
            end
            ST_PERM: begin
                perm_start_o = !perm_issued_q;
            end
            ST_CARRY: begin
                msg_o       = {{MSG_PAD_WIDTH{1'b0}}, carry_q};
                keep_o      = {{KEEP_PAD_WIDTH{1'b0}}, carry_keep_q};
                absorb_we_o = 1'b1;
            end
            ST_DONE: begin
                absorb_done_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bytes_absorbed_o = bytes_q;

endmodule
